// File: rtl/fft_frame_scheduler_pkg.sv
// Shared types and constants for the FFT frame scheduler: state encoding,
// default packet sync bytes and the bin-to-byte split.
package fft_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_SEND_HDR = 2'd2,
    ST_SEND_BIN = 2'd3
  } state_e;

  localparam logic [7:0]  SYNC0_DEF     = 8'hA5;
  localparam logic [7:0]  SYNC1_DEF     = 8'h5A;
  localparam int unsigned BYTES_PER_BIN = 3;

  // Bins are zero-extended to 24 bits and sent MSB first; bins wider than 24 bits are not supported.
  function automatic logic [7:0] bin_byte(input logic [23:0] bin, input logic [1:0] idx);
    case (idx)
      2'd0:    return bin[23:16];
      2'd1:    return bin[15:8];
      default: return bin[7:0];
    endcase
  endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Byte stream from the scheduler to the UART transmitter (valid/ready).
interface fft_frame_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/fft_frame_scheduler_frame_ram.sv
// Simple dual-port frame buffer: one write port for capture, one registered read port for send.
module fft_frame_scheduler_frame_ram #(
  parameter int unsigned NBINS = 64,
  parameter int unsigned DW    = 22,
  parameter int unsigned AW    = $clog2(NBINS)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [NBINS];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_frame_scheduler.sv
// Captures one FFT frame of bins and streams it to the UART as
// SYNC0, SYNC1, seq, then 3 bytes per bin; frames arriving mid-send are dropped whole.
module fft_frame_scheduler
  import fft_frame_scheduler_pkg::*;
#(
  parameter int unsigned NBINS = 64,
  parameter int unsigned DW    = 22,
  parameter logic [7:0]  SYNC0 = SYNC0_DEF,
  parameter logic [7:0]  SYNC1 = SYNC1_DEF
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  i_sample_ce,
  input  logic                  i_frame_start,
  input  logic [DW-1:0]         i_data,
  fft_frame_scheduler_if.master tx,
  output logic                  o_busy,
  output logic                  o_frame_drop,
  output logic [7:0]            o_seq
);

  localparam int unsigned   AW        = $clog2(NBINS);
  localparam logic [AW-1:0] LAST_BIN  = AW'(NBINS - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_BIN - 1);

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [1:0]    byte_cnt_q;
  logic [1:0]    hdr_cnt_q;
  logic [7:0]    seq_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          drop_q;
  logic [DW-1:0] bin_q;

  logic          start_strobe;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] rd_data;

  assign start_strobe = i_sample_ce & i_frame_start;
  assign accept       = tx_valid_q & tx.tx_ready;
  assign wr_en        = ((state_q == ST_IDLE) && start_strobe) ||
                        ((state_q == ST_CAPTURE) && i_sample_ce);
  assign wr_addr      = i_frame_start ? '0 : wr_ptr_q;

  fft_frame_scheduler_frame_ram #(
    .NBINS (NBINS),
    .DW    (DW),
    .AW    (AW)
  ) u_frame_ram (
    .clk_i     (sys_clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (i_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // rd_ptr_q always points one bin ahead of the bin being sent, so the RAM output
  // has settled on the next bin long before its first byte is needed; bin_q holds
  // the current bin for its remaining two bytes.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_cnt_q <= '0;
      hdr_cnt_q  <= '0;
      seq_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      drop_q     <= 1'b0;
      bin_q      <= '0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_strobe) begin
            wr_ptr_q <= AW'(1);
            state_q  <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (i_sample_ce) begin
            if (i_frame_start) begin
              wr_ptr_q <= AW'(1);
              drop_q   <= 1'b1;
            end else if (wr_ptr_q == LAST_BIN) begin
              wr_ptr_q   <= '0;
              rd_ptr_q   <= '0;
              hdr_cnt_q  <= '0;
              tx_data_q  <= SYNC0;
              tx_valid_q <= 1'b1;
              state_q    <= ST_SEND_HDR;
            end else begin
              wr_ptr_q <= wr_ptr_q + AW'(1);
            end
          end
        end

        ST_SEND_HDR: begin
          drop_q <= start_strobe;
          if (accept) begin
            if (hdr_cnt_q == 2'd2) begin
              bin_q      <= rd_data;
              tx_data_q  <= bin_byte(24'(rd_data), 2'd0);
              byte_cnt_q <= '0;
              rd_ptr_q   <= rd_ptr_q + AW'(1);
              state_q    <= ST_SEND_BIN;
            end else begin
              hdr_cnt_q <= hdr_cnt_q + 2'd1;
              tx_data_q <= (hdr_cnt_q == 2'd0) ? SYNC1 : seq_q;
            end
          end
        end

        ST_SEND_BIN: begin
          drop_q <= start_strobe;
          if (accept) begin
            if (byte_cnt_q != LAST_BYTE) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              tx_data_q  <= bin_byte(24'(bin_q), byte_cnt_q + 2'd1);
            end else if (rd_ptr_q == '0) begin
              // prefetch pointer wrapped: the last bin's last byte was just taken
              tx_valid_q <= 1'b0;
              seq_q      <= seq_q + 8'd1;
              state_q    <= ST_IDLE;
            end else begin
              bin_q      <= rd_data;
              tx_data_q  <= bin_byte(24'(rd_data), 2'd0);
              byte_cnt_q <= '0;
              rd_ptr_q   <= rd_ptr_q + AW'(1);
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx.tx_data   = tx_data_q;
  assign tx.tx_valid  = tx_valid_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_drop = drop_q;
  assign o_seq        = seq_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench: byte stream compared against a packet model built from the frame contents.
module tb_fft_frame_scheduler;

  localparam int NB  = 64;
  localparam int PKT = 3 + 3 * NB;

  logic        sys_clock     = 1'b0;
  logic        reset         = 1'b0;
  logic        i_sample_ce   = 1'b0;
  logic        i_frame_start = 1'b0;
  logic [21:0] i_data        = '0;
  logic        o_busy;
  logic        o_frame_drop;
  logic [7:0]  o_seq;

  fft_frame_scheduler_if tx_if ();

  fft_frame_scheduler #(.NBINS(NB), .DW(22)) dut (
    .sys_clock     (sys_clock),
    .reset         (reset),
    .i_sample_ce   (i_sample_ce),
    .i_frame_start (i_frame_start),
    .i_data        (i_data),
    .tx            (tx_if),
    .o_busy        (o_busy),
    .o_frame_drop  (o_frame_drop),
    .o_seq         (o_seq)
  );

  always #5 sys_clock = ~sys_clock;

  int         vectors      = 0;
  int         miscompares  = 0;
  int         drop_cnt     = 0;
  int         valid_cycles = 0;
  int         stall_seen   = 0;
  int         ready_mode   = 0;
  int         cyc          = 0;
  int         seq_m        = 0;
  logic       stall_pend   = 1'b0;
  logic [7:0] stall_data   = '0;
  int         frame_m [NB];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  // ready pattern: 0 = always, 1 = one cycle in three, else random
  initial begin
    tx_if.tx_ready = 1'b0;
    forever begin
      @(posedge sys_clock);
      #1;
      cyc++;
      case (ready_mode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = ((cyc % 3) == 0);
        default: tx_if.tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge sys_clock);
      if (reset) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          vectors++;
          if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== stall_data) begin
            miscompares++;
            $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                     tx_if.tx_valid, tx_if.tx_data, stall_data);
          end
        end
        if (tx_if.tx_valid === 1'b1) valid_cycles++;
        if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) rx_q.push_back(tx_if.tx_data);
        stall_pend = (tx_if.tx_valid === 1'b1) && (tx_if.tx_ready === 1'b0);
        if (stall_pend) stall_seen++;
        stall_data = tx_if.tx_data;
        if (o_frame_drop === 1'b1) drop_cnt++;
      end
    end
  end

  task automatic strobe(input bit fs, input int d);
    @(posedge sys_clock);
    #1;
    i_sample_ce   = 1'b1;
    i_frame_start = fs;
    i_data        = d[21:0];
  endtask

  task automatic release_inputs();
    @(posedge sys_clock);
    #1;
    i_sample_ce   = 1'b0;
    i_frame_start = 1'b0;
  endtask

  task automatic fill_random();
    for (int b = 0; b < NB; b++) frame_m[b] = $urandom_range(0, 4194303);
  endtask

  task automatic drive_frame();
    for (int b = 0; b < NB; b++) strobe(b == 0, frame_m[b]);
    release_inputs();
  endtask

  task automatic build_expected();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(seq_m));
    for (int b = 0; b < NB; b++) begin
      exp_q.push_back(8'((frame_m[b] / 65536) % 256));
      exp_q.push_back(8'((frame_m[b] / 256) % 256));
      exp_q.push_back(8'(frame_m[b] % 256));
    end
  endtask

  task automatic wait_rx(input string name, input int count, input int limit);
    int waited = 0;
    while (rx_q.size() < count && waited < limit) begin
      @(posedge sys_clock);
      waited++;
    end
    vectors++;
    if (rx_q.size() < count) begin
      miscompares++;
      $display("FAIL %s_wait: got %0d bytes, required %0d", name, rx_q.size(), count);
    end
  endtask

  task automatic check_packet(input string name, input int limit);
    int waited = 0;
    int bad    = 0;
    while (rx_q.size() < exp_q.size() && waited < limit) begin
      @(posedge sys_clock);
      waited++;
    end
    @(negedge sys_clock);
    vectors++;
    if (rx_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_len: got %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (rx_q[i] !== exp_q[i]) begin
          miscompares++;
          bad++;
          if (bad <= 4)
            $display("FAIL %s_byte[%0d]: got %h, required %h", name, i, rx_q[i], exp_q[i]);
        end
      end
    end
    seq_m = (seq_m + 1) % 256;
    vectors++;
    if (o_seq !== 8'(seq_m)) begin
      miscompares++;
      $display("FAIL %s_seq: got %h, required %h", name, o_seq, 8'(seq_m));
    end
    vectors++;
    if (o_busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b valid=%b, required 0 0", name, o_busy, tx_if.tx_valid);
    end
    rx_q.delete();
  endtask

  task automatic apply_reset();
    @(posedge sys_clock);
    #3;
    reset = 1'b1;
    repeat (2) @(posedge sys_clock);
    #3;
    reset = 1'b0;
    rx_q.delete();
    seq_m = 0;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    repeat (2) @(posedge sys_clock);
    @(negedge sys_clock);
    vectors++;
    if (tx_if.tx_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b, required 0", tx_if.tx_valid);
    end
    vectors++;
    if (tx_if.tx_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_data: got %h, required 00", tx_if.tx_data);
    end
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b, required 0", o_busy);
    end
    vectors++;
    if (o_frame_drop !== 1'b0) begin
      miscompares++; $display("FAIL reset_drop: got %b, required 0", o_frame_drop);
    end
    vectors++;
    if (o_seq !== 8'h00) begin
      miscompares++; $display("FAIL reset_seq: got %h, required 00", o_seq);
    end
    @(posedge sys_clock);
    #3;
    reset = 1'b0;
    seq_m = 0;
    rx_q.delete();
  endtask

  task automatic test_idle_ignore();
    ready_mode = 0;
    for (int k = 0; k < 6; k++) strobe(1'b0, int'($urandom_range(0, 4194303)));
    release_inputs();
    repeat (3) @(negedge sys_clock);
    vectors++;
    if (o_busy !== 1'b0 || tx_if.tx_valid !== 1'b0 || rx_q.size() != 0) begin
      miscompares++;
      $display("FAIL idle_ignore: busy=%b valid=%b bytes=%0d, required 0 0 0",
               o_busy, tx_if.tx_valid, rx_q.size());
    end
  endtask

  task automatic test_basic();
    ready_mode = 0;
    for (int b = 0; b < NB; b++) frame_m[b] = 4194303 - b;
    build_expected();
    valid_cycles = 0;
    for (int b = 0; b < NB; b++) strobe(b == 0, frame_m[b]);
    @(negedge sys_clock);
    vectors++;
    if (tx_if.tx_valid !== 1'b0) begin
      miscompares++; $display("FAIL latency_pre: valid=%b, required 0", tx_if.tx_valid);
    end
    release_inputs();
    @(negedge sys_clock);
    vectors++;
    if (tx_if.tx_valid !== 1'b1 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_post: valid=%b busy=%b, required 1 1", tx_if.tx_valid, o_busy);
    end
    check_packet("basic", 1000);
    vectors++;
    if (valid_cycles != PKT) begin
      miscompares++;
      $display("FAIL back_to_back: valid cycles %0d, required %0d", valid_cycles, PKT);
    end
  endtask

  task automatic test_stall();
    ready_mode = 1;
    stall_seen = 0;
    build_expected();
    drive_frame();
    check_packet("stall", 3000);
    ready_mode = 0;
    vectors++;
    if (stall_seen < 150) begin
      miscompares++; $display("FAIL stall_count: got %0d stalls, required >= 150", stall_seen);
    end
  endtask

  task automatic test_drop_mid_send();
    int d0;
    ready_mode = 2;
    fill_random();
    build_expected();
    drive_frame();
    wait_rx("drop_send", 50, 2000);
    d0 = drop_cnt;
    strobe(1'b1, int'($urandom_range(0, 4194303)));
    for (int k = 0; k < 5; k++) strobe(1'b0, int'($urandom_range(0, 4194303)));
    release_inputs();
    @(negedge sys_clock);
    vectors++;
    if (drop_cnt - d0 != 1) begin
      miscompares++; $display("FAIL drop_send_pulse: got %0d pulses, required 1", drop_cnt - d0);
    end
    check_packet("drop_send", 3000);
    fill_random();
    build_expected();
    drive_frame();
    check_packet("after_drop", 3000);
    ready_mode = 0;
  endtask

  task automatic test_restart_capture();
    int d0;
    ready_mode = 0;
    d0 = drop_cnt;
    for (int b = 0; b < 20; b++) strobe(b == 0, int'($urandom_range(0, 4194303)));
    fill_random();
    build_expected();
    for (int b = 0; b < NB; b++) strobe(b == 0, frame_m[b]);
    release_inputs();
    vectors++;
    if (drop_cnt - d0 != 1) begin
      miscompares++; $display("FAIL restart_pulse: got %0d pulses, required 1", drop_cnt - d0);
    end
    check_packet("restart", 1000);
  endtask

  task automatic test_reset_mid_send();
    ready_mode = 2;
    fill_random();
    drive_frame();
    wait_rx("reset_send", 100, 2000);
    @(posedge sys_clock);
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (tx_if.tx_valid !== 1'b0 || o_busy !== 1'b0 || o_seq !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_abort: valid=%b busy=%b seq=%h, required 0 0 00",
               tx_if.tx_valid, o_busy, o_seq);
    end
    repeat (2) @(posedge sys_clock);
    #3;
    reset = 1'b0;
    rx_q.delete();
    seq_m = 0;
    ready_mode = 0;
    fill_random();
    build_expected();
    drive_frame();
    check_packet("post_reset", 1000);
  endtask

  task automatic test_seq_wrap();
    ready_mode = 0;
    apply_reset();
    for (int k = 0; k < 257; k++) begin
      fill_random();
      build_expected();
      drive_frame();
      check_packet("wrap", 1000);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_stall();
    test_drop_mid_send();
    test_restart_capture();
    test_reset_mid_send();
    test_seq_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
